// File: rtl/dmem_stage.sv
// dmem_stage -- data-memory MEM stage for the 5-stage RV32I core.
//
// Runs LB/LH/LW/LBU/LHU/SB/SH/SW against an internal word array. An access
// can take WAIT_CYCLES extra cycles. While it does, STALL freezes IF..EX
// and the EX/MEM register. The result comes out one cycle after the
// array access, as a single-cycle pulse.
//
// Parameters:
//   DMEM_BASE    byte base address of the DMEM window
//   DMEM_SIZE    DMEM depth in 32-bit words (power of two)
//   DMEM_FILE    init image name for the memory loader (not read by this RTL)
//   WAIT_CYCLES  extra access latency, 0..15
//
// Ports:
//   CLK        clock
//   RST        synchronous active-high reset
//   REQ_M      memory op present in EX/MEM
//   WE_M       1 = store, 0 = load
//   FT_M       funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
//   ADDR_M     byte address
//   WDATA_M    store data
//   STALL      hold IF/ID/EX and EX/MEM this cycle (combinational)
//   RDATA_MW   load result, extended to 32 bits (0 for stores and faults)
//   RVALID_MW  one-cycle pulse when an op completes
//   FAULT_MW   one-cycle pulse together with RVALID_MW when the op is rejected
//
// Configuration macro:
//   DMEM_MISALIGN_TRAP_EN  when defined, misaligned H/HU/SH/W/SW fault.
//                          When undefined, the low address bits that do not
//                          fit the access size are ignored.
//
// Byte order: address byte k of a word sits in word bits [31-8k -: 8].

module dmem_stage #(
    parameter logic [31:0] DMEM_BASE   = 32'h0010_0000,
    parameter int          DMEM_SIZE   = 32768,
    parameter string       DMEM_FILE   = "data.mif",
    parameter int          WAIT_CYCLES = 0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        REQ_M,
    input  logic        WE_M,
    input  logic [2:0]  FT_M,
    input  logic [31:0] ADDR_M,
    input  logic [31:0] WDATA_M,
    output logic        STALL,
    output logic [31:0] RDATA_MW,
    output logic        RVALID_MW,
    output logic        FAULT_MW
);

    localparam int          AW    = $clog2(DMEM_SIZE);
    localparam logic [32:0] LIMIT = 33'(DMEM_SIZE) * 33'd4;
    localparam logic [3:0]  NWAIT = 4'(WAIT_CYCLES);

    typedef struct packed {
        logic        we;
        logic [2:0]  ft;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       go;          // perform the array access at this clock edge
    mem_req_t   held, live, op;

    logic [31:0]   mem [DMEM_SIZE];

    logic [31:0]   off;
    logic [1:0]    lane;
    logic [AW-1:0] idx;
    logic          in_range, ft_bad, misal, fault;
    logic [3:0]    be;
    logic [31:0]   wpos, word, ext;
    logic [7:0]    byte_v;
    logic [15:0]   half_v;

    assign live = '{we: WE_M, ft: FT_M, addr: ADDR_M, wdata: WDATA_M};
    // Once the op is in WAIT, the copy latched at accept is used.
    // Later changes on the inputs are ignored.
    assign op   = (state == S_WAIT) ? held : live;

    // ---------------- control ----------------
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        STALL     = 1'b0;
        go        = 1'b0;
        case (state)
            S_IDLE: begin
                if (REQ_M) begin
                    if (NWAIT == 4'd0) begin
                        go = 1'b1;
                    end else begin
                        STALL     = 1'b1;
                        state_nxt = S_WAIT;
                        cnt_nxt   = NWAIT - 4'd1;
                    end
                end
            end
            S_WAIT: begin
                // The counter reaches 0 in the last cycle of the op. STALL
                // drops in that cycle so that EX/MEM can load the next op.
                if (cnt == 4'd0) begin
                    go        = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    STALL   = 1'b1;
                    cnt_nxt = cnt - 4'd1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (RST) begin
            STALL = 1'b0;
            go    = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
            held  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == S_IDLE && REQ_M)
                held <= live;
        end
    end

    // ---------------- decode ----------------
    assign off      = op.addr - DMEM_BASE;   // 32-bit wrap is intended
    assign in_range = {1'b0, off} < LIMIT;
    assign lane     = off[1:0];
    assign idx      = off[AW+1:2];
    assign ft_bad   = (op.ft == 3'b011) || (op.ft[2:1] == 2'b11) || (op.we && op.ft[2]);

`ifdef DMEM_MISALIGN_TRAP_EN
    assign misal = ((op.ft[1:0] == 2'b01) && off[0]) ||
                   ((op.ft[1:0] == 2'b10) && (off[1:0] != 2'b00));
`else
    assign misal = 1'b0;
`endif

    assign fault = !in_range || ft_bad || misal;

    // Byte enable: bit k selects address byte k.
    always_comb begin
        case (op.ft[1:0])
            2'b00:   begin be = 4'b0001 << lane;                    wpos = {4{op.wdata[7:0]}};  end
            2'b01:   begin be = off[1] ? 4'b1100 : 4'b0011;         wpos = {2{op.wdata[15:0]}}; end
            default: begin be = 4'b1111;                            wpos = op.wdata;            end
        endcase
    end

    // ---------------- read path ----------------
    assign word   = mem[idx];
    assign half_v = off[1] ? word[15:0] : word[31:16];

    always_comb begin
        case (lane)
            2'd0:    byte_v = word[31:24];
            2'd1:    byte_v = word[23:16];
            2'd2:    byte_v = word[15:8];
            default: byte_v = word[7:0];
        endcase
    end

    always_comb begin
        case (op.ft)
            3'b000:  ext = {{24{byte_v[7]}}, byte_v};
            3'b001:  ext = {{16{half_v[15]}}, half_v};
            3'b100:  ext = {24'd0, byte_v};
            3'b101:  ext = {16'd0, half_v};
            default: ext = word;
        endcase
    end

    // ---------------- array write ----------------
    always_ff @(posedge CLK) begin
        if (go && !fault && op.we) begin
            for (int k = 0; k < 4; k++)
                if (be[k])
                    mem[idx][31-8*k -: 8] <= wpos[31-8*k -: 8];
        end
    end

    // ---------------- result register ----------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            RVALID_MW <= 1'b0;
            FAULT_MW  <= 1'b0;
            RDATA_MW  <= 32'd0;
        end else begin
            RVALID_MW <= go;
            FAULT_MW  <= go && fault;
            RDATA_MW  <= (go && !fault && !op.we) ? ext : 32'd0;
        end
    end

endmodule

// File: tb/tb_dmem_stage.sv
module tb_dmem_stage;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        req   [2];
    logic        we    [2];
    logic [2:0]  ft    [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic        stall [2];
    logic [31:0] rdata [2];
    logic        rvalid[2];
    logic        fault [2];

    int n_chk = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    // u0: zero wait states, u1: three wait states
    dmem_stage #(.WAIT_CYCLES(0)) u0 (
        .CLK(CLK), .RST(RST), .REQ_M(req[0]), .WE_M(we[0]), .FT_M(ft[0]),
        .ADDR_M(addr[0]), .WDATA_M(wdata[0]), .STALL(stall[0]),
        .RDATA_MW(rdata[0]), .RVALID_MW(rvalid[0]), .FAULT_MW(fault[0]));

    dmem_stage #(.WAIT_CYCLES(3)) u1 (
        .CLK(CLK), .RST(RST), .REQ_M(req[1]), .WE_M(we[1]), .FT_M(ft[1]),
        .ADDR_M(addr[1]), .WDATA_M(wdata[1]), .STALL(stall[1]),
        .RDATA_MW(rdata[1]), .RVALID_MW(rvalid[1]), .FAULT_MW(fault[1]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Issue one op in the current cycle and hold it while STALL is high,
    // the way the pipeline does. Must be called at a negedge. Returns in
    // cycle t+N+1 with the outputs sampled, so the next call is back-to-back.
    task automatic do_op(input int u, input logic w, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] rd, output logic flt, output logic vld,
                         output int stalls, output logic early);
        req[u] = 1'b1; we[u] = w; ft[u] = f; addr[u] = a; wdata[u] = d;
        stalls = 0; early = 1'b0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (i > 0 && rvalid[u]) early = 1'b1;
            if (!stall[u]) break;
            stalls++;
            @(negedge CLK);
        end
        @(negedge CLK);
        #1;
        rd = rdata[u]; flt = fault[u]; vld = rvalid[u];
        req[u] = 1'b0;
    endtask

    logic [31:0] rd;
    logic        flt, vld, early, seen;
    int          st;

    // Load helper: checks value, fault, valid and stall count.
    task automatic ld(input string tag, input int u, input logic [2:0] f, input logic [31:0] a,
                      input logic [31:0] exp_d, input logic exp_f);
        do_op(u, 1'b0, f, a, 32'd0, rd, flt, vld, st, early);
        chk({tag, ".data"}, rd, exp_d);
        chk({tag, ".fault"}, {31'd0, flt}, {31'd0, exp_f});
        chk({tag, ".valid"}, {31'd0, vld}, 32'd1);
        chk({tag, ".stalls"}, st, (u == 0) ? 32'd0 : 32'd3);
    endtask

    task automatic stw(input string tag, input int u, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] d, input logic exp_f);
        do_op(u, 1'b1, f, a, d, rd, flt, vld, st, early);
        chk({tag, ".data"}, rd, 32'd0);
        chk({tag, ".fault"}, {31'd0, flt}, {31'd0, exp_f});
        chk({tag, ".valid"}, {31'd0, vld}, 32'd1);
    endtask

    initial begin
        for (int u = 0; u < 2; u++) begin
            req[u] = 1'b1; we[u] = 1'b0; ft[u] = 3'b010;
            addr[u] = 32'h0010_0000; wdata[u] = 32'd0;
        end
        // reset with REQ_M asserted: STALL must stay low
        repeat (2) @(negedge CLK);
        #1;
        chk("rst.stall1", {31'd0, stall[1]}, 32'd0);
        chk("rst.valid0", {31'd0, rvalid[0]}, 32'd0);
        chk("rst.valid1", {31'd0, rvalid[1]}, 32'd0);
        chk("rst.fault1", {31'd0, fault[1]}, 32'd0);
        chk("rst.rdata1", rdata[1], 32'd0);
        req[0] = 1'b0; req[1] = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);

        // ---- N=0 instance ----
        stw("t1.sw", 0, 3'b010, 32'h0010_0000, 32'hDEAD_BEEF, 1'b0);
        chk("t1.sw.stalls", st, 32'd0);
        ld ("t1.lw", 0, 3'b010, 32'h0010_0000, 32'hDEAD_BEEF, 1'b0);
`ifdef DMEM_MISALIGN_TRAP_EN
        ld ("t6.lw_mis", 0, 3'b010, 32'h0010_0002, 32'h0000_0000, 1'b1);
        ld ("t6.lh_mis", 0, 3'b001, 32'h0010_0001, 32'h0000_0000, 1'b1);
`else
        ld ("t6.lw_mis", 0, 3'b010, 32'h0010_0002, 32'hDEAD_BEEF, 1'b0);
        ld ("t6.lh_mis", 0, 3'b001, 32'h0010_0001, 32'hFFFF_DEAD, 1'b0);
`endif
        stw("t2.sb", 0, 3'b000, 32'h0010_0001, 32'h0000_0080, 1'b0);
        ld ("t2.lb",  0, 3'b000, 32'h0010_0001, 32'hFFFF_FF80, 1'b0);
        ld ("t2.lbu", 0, 3'b100, 32'h0010_0001, 32'h0000_0080, 1'b0);
        ld ("t2.lw",  0, 3'b010, 32'h0010_0000, 32'hDE80_BEEF, 1'b0);
        ld ("t2.lh",  0, 3'b001, 32'h0010_0002, 32'hFFFF_BEEF, 1'b0);
        ld ("t2.lhu", 0, 3'b101, 32'h0010_0000, 32'h0000_DE80, 1'b0);
        ld ("t2.lb3", 0, 3'b000, 32'h0010_0003, 32'hFFFF_FFEF, 1'b0);
        stw("t2.sh", 0, 3'b001, 32'h0010_0002, 32'h0000_1234, 1'b0);
        ld ("t2.lw2", 0, 3'b010, 32'h0010_0000, 32'hDE80_1234, 1'b0);
        stw("t2.sb_ft", 0, 3'b100, 32'h0010_0000, 32'h0000_0011, 1'b1);
        ld ("t2.ft011", 0, 3'b011, 32'h0010_0000, 32'h0000_0000, 1'b1);
        ld ("t2.ft110", 0, 3'b110, 32'h0010_0000, 32'h0000_0000, 1'b1);
        ld ("t2.lw3", 0, 3'b010, 32'h0010_0000, 32'hDE80_1234, 1'b0);

        // ---- N=3 instance ----
        stw("t3.sw", 1, 3'b010, 32'h0010_0000, 32'h1122_3344, 1'b0);
        chk("t3.sw.stalls", st, 32'd3);
        do_op(1, 1'b0, 3'b010, 32'h0010_0000, 32'd0, rd, flt, vld, st, early);
        chk("t3.lw.data", rd, 32'h1122_3344);
        chk("t3.lw.stalls", st, 32'd3);
        chk("t3.lw.early", {31'd0, early}, 32'd0);
        chk("t3.lw.valid", {31'd0, vld}, 32'd1);
        // back-to-back: issued in the cycle the previous result appears
        do_op(1, 1'b0, 3'b000, 32'h0010_0003, 32'd0, rd, flt, vld, st, early);
        chk("t3.b2b.data", rd, 32'h0000_0044);
        chk("t3.b2b.stalls", st, 32'd3);
        chk("t3.b2b.early", {31'd0, early}, 32'd0);
        chk("t3.b2b.valid", {31'd0, vld}, 32'd1);

        ld ("t4.lw_oor", 1, 3'b010, 32'h0000_0010, 32'h0000_0000, 1'b1);
        stw("t4.sw_end", 1, 3'b010, 32'h0012_0000, 32'h5555_5555, 1'b1);
        stw("t4.sw_last", 1, 3'b010, 32'h0011_FFFC, 32'hAABB_CCDD, 1'b0);
        ld ("t4.lw_last", 1, 3'b010, 32'h0011_FFFC, 32'hAABB_CCDD, 1'b0);
        ld ("t4.lw_chk", 1, 3'b010, 32'h0010_0000, 32'h1122_3344, 1'b0);

        // ---- reset during WAIT aborts the store ----
        stw("t5.sw_old", 1, 3'b010, 32'h0010_0004, 32'hCAFE_F00D, 1'b0);
        req[1] = 1'b1; we[1] = 1'b1; ft[1] = 3'b010;
        addr[1] = 32'h0010_0004; wdata[1] = 32'h0000_1234;
        #1;
        chk("t5.stall_t", {31'd0, stall[1]}, 32'd1);
        @(negedge CLK);
        RST = 1'b1;
        #1;
        chk("t5.stall_rst", {31'd0, stall[1]}, 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        req[1] = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (rvalid[1]) seen = 1'b1;
            @(negedge CLK);
        end
        chk("t5.no_valid", {31'd0, seen}, 32'd0);
        chk("t5.stall_after", {31'd0, stall[1]}, 32'd0);
        ld ("t5.lw_old", 1, 3'b010, 32'h0010_0004, 32'hCAFE_F00D, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
